// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Brief    : Shared types, default geometry and address-field helpers for
//             the direct-mapped write-through data cache.
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int OFF_W = 2;
    localparam int IDX_W = 4;
    localparam int TAG_W = 64 - 3 - OFF_W - IDX_W;

    // Helpers take the field widths so any legal geometry can reuse them.
    function automatic logic [63:0] get_offset(input logic [63:0] addr, input int offW);
        return (addr >> 3) & ((64'd1 << offW) - 64'd1);
    endfunction

    function automatic logic [63:0] get_index(input logic [63:0] addr, input int offW,
                                              input int idxW);
        return (addr >> (3 + offW)) & ((64'd1 << idxW) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr, input int offW,
                                            input int idxW);
        return addr >> (3 + offW + idxW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_line_array
//  Brief    : Valid/tag/data storage; one-word synchronous write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_line_array #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 4,
    parameter int OFF_W          = 2,
    parameter int TAG_W          = 55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rdIndex,
    input  logic [OFF_W-1:0]  rdOffset,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [63:0]       rdData,
    input  logic              wrEn,
    input  logic              wrSetValid,
    input  logic [IDX_W-1:0]  wrIndex,
    input  logic [OFF_W-1:0]  wrOffset,
    input  logic [TAG_W-1:0]  wrTag,
    input  logic [63:0]       wrData
);

    logic [63:0]      r_data [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (wrEn && wrSetValid) begin
            r_valid[wrIndex] <= 1'b1;
        end
    end

    // Data and tags need no reset: a line is only visible once valid is set.
    always_ff @(posedge clk) begin
        if (wrEn && !reset) begin
            r_data[wrIndex][wrOffset] <= wrData;
            if (wrSetValid) begin
                r_tag[wrIndex] <= wrTag;
            end
        end
    end

    assign rdValid = r_valid[rdIndex];
    assign rdTag   = r_tag[rdIndex];
    assign rdData  = r_data[rdIndex][rdOffset];

endmodule
`default_nettype wire

// File: rtl/dcache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_dm
//  Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//             a req/ack backing-memory port and a pipeline stall output.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int LINES          = 1 << IDX_W,
    parameter int WORDS_PER_LINE = 1 << OFF_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    input  logic [63:0] cpu_address,
    input  logic [63:0] cpu_write_data,
    output logic [63:0] cpu_read_data,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic        mem_ack,
    input  logic [63:0] mem_read_data
);

    localparam int C_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int C_IDX_W = $clog2(LINES);
    localparam int C_TAG_W = 64 - 3 - C_OFF_W - C_IDX_W;
    localparam logic [C_OFF_W-1:0] C_LAST_BEAT = C_OFF_W'(WORDS_PER_LINE - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [C_OFF_W-1:0]   r_beat;
    logic [63:0]          r_addr;
    logic [63:0]          r_wrData;

    logic [63:0]          w_lookupAddr;
    logic                 w_rdValid;
    logic [C_TAG_W-1:0]   w_rdTag;
    logic [63:0]          w_rdData;
    logic                 w_hit;
    logic                 w_arrWe;
    logic                 w_arrSetValid;
    logic [C_OFF_W-1:0]   w_arrWrOff;
    logic [63:0]          w_arrWrData;
    logic                 w_latchFill;
    logic                 w_latchWrite;

    // WRITE checks the latched store address; otherwise look up the live request.
    assign w_lookupAddr = (r_state == WRITE) ? r_addr : cpu_address;
    assign w_hit = w_rdValid &&
                   (w_rdTag == C_TAG_W'(get_tag(w_lookupAddr, C_OFF_W, C_IDX_W)));

    dcache_line_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (C_IDX_W),
        .OFF_W          (C_OFF_W),
        .TAG_W          (C_TAG_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .rdIndex    (C_IDX_W'(get_index(w_lookupAddr, C_OFF_W, C_IDX_W))),
        .rdOffset   (C_OFF_W'(get_offset(w_lookupAddr, C_OFF_W))),
        .rdValid    (w_rdValid),
        .rdTag      (w_rdTag),
        .rdData     (w_rdData),
        .wrEn       (w_arrWe),
        .wrSetValid (w_arrSetValid),
        .wrIndex    (C_IDX_W'(get_index(r_addr, C_OFF_W, C_IDX_W))),
        .wrOffset   (w_arrWrOff),
        .wrTag      (C_TAG_W'(get_tag(r_addr, C_OFF_W, C_IDX_W))),
        .wrData     (w_arrWrData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_addr   <= '0;
            r_wrData <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_latchFill) begin
                r_addr <= cpu_address & ~((64'd1 << (3 + C_OFF_W)) - 64'd1);
                r_beat <= '0;
            end
            if (w_latchWrite) begin
                r_addr   <= cpu_address & ~64'd7;
                r_wrData <= cpu_write_data;
            end
            if (r_state == FILL && mem_ack) begin
                r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        cpu_stall      = 1'b0;
        cpu_read_data  = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_address    = r_addr;
        mem_write_data = r_wrData;
        w_arrWe        = 1'b0;
        w_arrSetValid  = 1'b0;
        w_arrWrOff     = r_beat;
        w_arrWrData    = mem_read_data;
        w_latchFill    = 1'b0;
        w_latchWrite   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_write_en) begin
                    cpu_stall    = 1'b1;
                    w_latchWrite = 1'b1;
                    w_nextState  = WRITE;
                end else if (cpu_read_en) begin
                    if (w_hit) begin
                        cpu_read_data = w_rdData;
                    end else begin
                        cpu_stall   = 1'b1;
                        w_latchFill = 1'b1;
                        w_nextState = FILL;
                    end
                end
            end
            FILL: begin
                mem_req     = 1'b1;
                cpu_stall   = 1'b1;
                mem_address = r_addr + (64'(r_beat) << 3);
                if (mem_ack) begin
                    w_arrWe = 1'b1;
                    if (r_beat == C_LAST_BEAT) begin
                        w_arrSetValid = 1'b1;
                        w_nextState   = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = ~mem_ack;
                if (mem_ack) begin
                    w_nextState = IDLE;
                    // Keep a resident copy coherent; misses are not allocated.
                    if (w_hit) begin
                        w_arrWe     = 1'b1;
                        w_arrWrOff  = C_OFF_W'(get_offset(r_addr, C_OFF_W));
                        w_arrWrData = r_wrData;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_dm
//  Brief    : Directed self-checking bench for dcache_dm with a req/ack memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [63:0] cpu_address;
    logic [63:0] cpu_write_data;
    logic [63:0] cpu_read_data;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_ack;
    logic [63:0] mem_read_data;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } beat_t;

    int          ackDelay;
    int          ackCnt;
    logic [63:0] bmem [0:2047];
    beat_t       beatLog [$];
    int          nCompared = 0;
    int          nMismatch = 0;

    dcache_dm dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read_en    (cpu_read_en),
        .cpu_write_en   (cpu_write_en),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pattern(input int i);
        if (i >= 32 && i <= 35)       return 64'hA0 + 64'(i - 32);
        else if (i >= 96 && i <= 99)  return 64'hB0 + 64'(i - 96);
        else                          return 64'hF000_0000_0000_0000 | 64'(i);
    endfunction

    // Backing memory: acks a request after ackDelay waiting cycles.
    assign mem_ack       = mem_req && (ackCnt == ackDelay);
    assign mem_read_data = bmem[mem_address[13:3]];

    always @(posedge clk) begin
        beat_t b;
        if (mem_req && !mem_ack) ackCnt <= ackCnt + 1;
        else                     ackCnt <= 0;
        if (reset) begin
            for (int i = 0; i < 2048; i++) bmem[i] <= pattern(i);
        end else if (mem_req && mem_ack) begin
            b.we   = mem_we;
            b.addr = mem_address;
            b.data = mem_we ? mem_write_data : mem_read_data;
            beatLog.push_back(b);
            if (mem_we) bmem[mem_address[13:3]] <= mem_write_data;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each op starts just after a rising edge and ends just after the edge
    // that retires it.
    task automatic doRead(input logic [63:0] addr, output logic [63:0] data,
                          output int stalls, output int reqCycles);
        bit done = 0;
        beatLog.delete();
        cpu_read_en = 1'b1;
        cpu_address = addr;
        stalls = 0;
        reqCycles = 0;
        data = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_req) reqCycles++;
            if (cpu_stall) stalls++;
            else begin
                done = 1;
                data = cpu_read_data;
            end
        end
        if (!done) checkVal("read_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cpu_read_en = 1'b0;
    endtask

    task automatic doWrite(input logic [63:0] addr, input logic [63:0] data,
                           output int stalls, output int reqCycles);
        bit done = 0;
        beatLog.delete();
        cpu_write_en   = 1'b1;
        cpu_address    = addr;
        cpu_write_data = data;
        stalls = 0;
        reqCycles = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) reqCycles++;
            if (cpu_stall) stalls++;
            else done = 1;
        end
        if (!done) checkVal("write_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cpu_write_en = 1'b0;
    endtask

    task automatic checkFill(input string tag, input logic [63:0] base);
        checkVal({tag, "_beats"}, 64'(beatLog.size()), 64'd4);
        for (int i = 0; i < beatLog.size() && i < 4; i++) begin
            checkVal({tag, "_addr"}, beatLog[i].addr, base + 64'(i * 8));
            checkVal({tag, "_we"}, 64'(beatLog[i].we), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rd;
        int          st;
        int          rq;
        bit          hit2;

        reset = 1'b1;
        cpu_read_en = 1'b0;
        cpu_write_en = 1'b0;
        cpu_address = '0;
        cpu_write_data = '0;
        ackDelay = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkVal("rst_stall", 64'(cpu_stall), 64'd0);
        checkVal("rst_req", 64'(mem_req), 64'd0);
        checkVal("rst_we", 64'(mem_we), 64'd0);
        checkVal("rst_rdata", cpu_read_data, 64'd0);
        @(posedge clk); #1;

        // Cold miss, memory waits one cycle per beat: 1 detect + 4*2 stall cycles.
        ackDelay = 1;
        doRead(64'h100, rd, st, rq);
        checkVal("cold_data", rd, 64'hA0);
        checkVal("cold_stalls", 64'(st), 64'd9);
        checkVal("cold_reqcyc", 64'(rq), 64'd8);
        checkFill("cold", 64'h100);

        doRead(64'h108, rd, st, rq);
        checkVal("hit_data", rd, 64'hA1);
        checkVal("hit_stalls", 64'(st), 64'd0);
        checkVal("hit_req", 64'(rq), 64'd0);

        // Write hit with ack on the fourth request cycle.
        ackDelay = 3;
        doWrite(64'h110, 64'h55, st, rq);
        checkVal("wh_stalls", 64'(st), 64'd4);
        checkVal("wh_reqcyc", 64'(rq), 64'd4);
        checkVal("wh_beats", 64'(beatLog.size()), 64'd1);
        if (beatLog.size() > 0) begin
            checkVal("wh_addr", beatLog[0].addr, 64'h110);
            checkVal("wh_data", beatLog[0].data, 64'h55);
        end
        doRead(64'h110, rd, st, rq);
        checkVal("wh_rdata", rd, 64'h55);
        checkVal("wh_rstalls", 64'(st), 64'd0);

        // Write miss: one write beat, no allocate; re-read must fill from memory.
        ackDelay = 0;
        doWrite(64'h2000, 64'h77, st, rq);
        checkVal("wm_beats", 64'(beatLog.size()), 64'd1);
        if (beatLog.size() > 0) begin
            checkVal("wm_addr", beatLog[0].addr, 64'h2000);
            checkVal("wm_we", 64'(beatLog[0].we), 64'd1);
        end
        doRead(64'h2000, rd, st, rq);
        checkVal("wm_rdata", rd, 64'h77);
        checkVal("wm_rstalls", 64'(st), 64'd5);
        checkFill("wm_fill", 64'h2000);

        // Conflict on index 8.
        doRead(64'h100, rd, st, rq);
        checkVal("cf_hit_data", rd, 64'hA0);
        checkVal("cf_hit_stalls", 64'(st), 64'd0);
        doRead(64'h300, rd, st, rq);
        checkVal("cf_new_data", rd, 64'hB0);
        checkFill("cf_new", 64'h300);
        doRead(64'h118, rd, st, rq);
        checkVal("cf_evict_data", rd, 64'hA3);
        checkVal("cf_evict_stalls", 64'(st), 64'd5);
        checkFill("cf_evict", 64'h100);

        // Reset after two of four fill beats.
        beatLog.delete();
        cpu_read_en = 1'b1;
        cpu_address = 64'h300;
        hit2 = 0;
        for (int c = 0; c < 50 && !hit2; c++) begin
            @(negedge clk);
            if (beatLog.size() >= 2) hit2 = 1;
        end
        if (!hit2) checkVal("mr_timeout", 64'd0, 64'd1);
        reset = 1'b1;
        cpu_read_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkVal("mr_req", 64'(mem_req), 64'd0);
        checkVal("mr_stall", 64'(cpu_stall), 64'd0);
        checkVal("mr_rdata", cpu_read_data, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        doRead(64'h100, rd, st, rq);
        checkVal("mr_after_data", rd, 64'hA0);
        checkVal("mr_after_stalls", 64'(st), 64'd5);
        checkFill("mr_after", 64'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
